// File: rtl/fb_loader.sv
// Framebuffer loader: decodes a host byte stream of pixel/cursor/fill commands
// into one-pixel-per-cycle framebuffer writes with a raster-advancing cursor.
module fb_loader #(
  parameter int XW = 7,
  parameter int YW = 7,
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [PW-1:0] wr_data,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_X     = 3'd1,
    S_GET_Y     = 3'd2,
    S_GET_COLOR = 3'd3,
    S_FILL      = 3'd4
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_cur_x;
  logic [YW-1:0] r_cur_y;
  logic [PW-1:0] r_fill_color;
  logic          r_wr_en;
  logic [XW-1:0] r_wr_x;
  logic [YW-1:0] r_wr_y;
  logic [PW-1:0] r_wr_data;
  logic          r_frame_done;

  state_t        w_nxt_state;
  logic [XW-1:0] w_nxt_x;
  logic [YW-1:0] w_nxt_y;
  logic [PW-1:0] w_nxt_color;
  logic          w_nxt_wr_en;
  logic [XW-1:0] w_nxt_wr_x;
  logic [YW-1:0] w_nxt_wr_y;
  logic [PW-1:0] w_nxt_wr_data;
  logic          w_nxt_fd;

  logic          w_accept;
  logic          w_x_last;
  logic          w_y_last;
  logic [XW-1:0] w_adv_x;
  logic [YW-1:0] w_adv_y;

  assign in_ready   = (r_state != S_FILL);
  assign busy       = (r_state == S_FILL);
  assign wr_en      = r_wr_en;
  assign wr_x       = r_wr_x;
  assign wr_y       = r_wr_y;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;

  assign w_accept = in_valid & in_ready;
  assign w_x_last = (r_cur_x == {XW{1'b1}});
  assign w_y_last = (r_cur_y == {YW{1'b1}});
  // Cursor wraps naturally through modulo-width arithmetic; y steps only on x wrap.
  assign w_adv_x  = r_cur_x + XW'(1);
  assign w_adv_y  = w_x_last ? (r_cur_y + YW'(1)) : r_cur_y;

  // Next-state, cursor and write-port decode.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_x       = r_cur_x;
    w_nxt_y       = r_cur_y;
    w_nxt_color   = r_fill_color;
    w_nxt_wr_en   = 1'b0;
    w_nxt_wr_x    = r_wr_x;
    w_nxt_wr_y    = r_wr_y;
    w_nxt_wr_data = r_wr_data;
    w_nxt_fd      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (in_data[7:6] == 2'b00) begin
            w_nxt_wr_en   = 1'b1;
            w_nxt_wr_x    = r_cur_x;
            w_nxt_wr_y    = r_cur_y;
            w_nxt_wr_data = PW'(in_data[5:0]);
            w_nxt_x       = w_adv_x;
            w_nxt_y       = w_adv_y;
            w_nxt_fd      = w_x_last & w_y_last;
          end else if (in_data == 8'h40) begin
            w_nxt_state = S_GET_X;
          end else if (in_data == 8'h80) begin
            w_nxt_state = S_GET_COLOR;
          end else if (in_data == 8'hC0) begin
            w_nxt_x = {XW{1'b0}};
            w_nxt_y = {YW{1'b0}};
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_GET_X: begin
        if (w_accept) begin
          w_nxt_x     = in_data[XW-1:0];
          w_nxt_state = S_GET_Y;
        end else begin
          w_nxt_state = S_GET_X;
        end
      end
      S_GET_Y: begin
        if (w_accept) begin
          w_nxt_y     = in_data[YW-1:0];
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_state = S_GET_Y;
        end
      end
      S_GET_COLOR: begin
        if (w_accept) begin
          w_nxt_color = in_data[PW-1:0];
          w_nxt_x     = {XW{1'b0}};
          w_nxt_y     = {YW{1'b0}};
          w_nxt_state = S_FILL;
        end else begin
          w_nxt_state = S_GET_COLOR;
        end
      end
      S_FILL: begin
        w_nxt_wr_en   = 1'b1;
        w_nxt_wr_x    = r_cur_x;
        w_nxt_wr_y    = r_cur_y;
        w_nxt_wr_data = r_fill_color;
        w_nxt_x       = w_adv_x;
        w_nxt_y       = w_adv_y;
        if (w_x_last && w_y_last) begin
          w_nxt_fd    = 1'b1;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_state = S_FILL;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // State, cursor, fill colour and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_x      <= {XW{1'b0}};
      r_cur_y      <= {YW{1'b0}};
      r_fill_color <= {PW{1'b0}};
      r_wr_en      <= 1'b0;
      r_wr_x       <= {XW{1'b0}};
      r_wr_y       <= {YW{1'b0}};
      r_wr_data    <= {PW{1'b0}};
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cur_x      <= w_nxt_x;
      r_cur_y      <= w_nxt_y;
      r_fill_color <= w_nxt_color;
      r_wr_en      <= w_nxt_wr_en;
      r_wr_x       <= w_nxt_wr_x;
      r_wr_y       <= w_nxt_wr_y;
      r_wr_data    <= w_nxt_wr_data;
      r_frame_done <= w_nxt_fd;
    end
  end

endmodule

// File: doc/fb_loader.md
FB_LOADER -- requirements
Module: fb_loader

Interface
REQ-001 SHALL have parameter XW, default 7, framebuffer column address width (128 columns).
REQ-002 SHALL have parameter YW, default 7, framebuffer row address width (128 rows).
REQ-003 SHALL have parameter PW, default 6, pixel width (RRGGBB, 2 bits each).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_data  input  8  command/data byte stream from host.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-009 SHALL have port wr_en  output  1  framebuffer write strobe, one pixel per cycle.
REQ-010 SHALL have port wr_x  output  XW  write column.
REQ-011 SHALL have port wr_y  output  YW  write row.
REQ-012 SHALL have port wr_data  output  PW  write pixel value.
REQ-013 SHALL have port busy  output  1  high while in FILL.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a full frame has been written.

Function
REQ-015 SHALL decode an accepted byte in state IDLE as: 00pppppp = PIXEL, 0x40 = SET_XY, 0x80 = FILL, 0xC0 = HOME; any other value dropped with no effect.
REQ-016 SHALL implement states IDLE, GET_X, GET_Y, GET_COLOR, FILL; transitions only on accepted bytes except FILL exit.
REQ-017 PIXEL: SHALL register wr_en=1, wr_x/wr_y=cursor, wr_data=byte[5:0] in the cycle after acceptance (latency 1), then advance cursor.
REQ-018 Cursor advance SHALL be x+1; at x=2^XW-1, x wraps to 0 and y+1; at y=2^YW-1 with x wrap, y wraps to 0 and frame_done pulses together with that final wr_en.
REQ-019 SET_XY: IDLE -> GET_X; next accepted byte[XW-1:0] -> cursor x, -> GET_Y; next byte[YW-1:0] -> cursor y, -> IDLE; upper bits ignored; no write issued.
REQ-020 HOME: SHALL set cursor to (0,0) in the acceptance cycle, no write, no frame_done.
REQ-021 FILL: IDLE -> GET_COLOR; next accepted byte[PW-1:0] latched as fill colour -> FILL.
REQ-022 In FILL, SHALL issue wr_en every cycle over all 2^(XW+YW) addresses in raster order (x fastest) from (0,0), then return to IDLE with cursor at (0,0).
REQ-023 frame_done SHALL pulse with the last FILL write (127,127); busy SHALL be high exactly while state = FILL.
REQ-024 in_ready SHALL be 1 in IDLE, GET_X, GET_Y, GET_COLOR and 0 in FILL; in_ready SHALL be combinational from state only, never from in_valid.
REQ-025 wr_en SHALL be 0 in every cycle not following a PIXEL acceptance or not in FILL; wr_x/wr_y/wr_data are don't-care when wr_en=0.
REQ-026 Back-to-back PIXEL bytes SHALL yield one write per cycle with no bubbles.
REQ-027 Coordinate arithmetic SHALL be modulo 2^XW / 2^YW; no out-of-range address SHALL ever be driven.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, cursor (0,0), wr_en 0, busy 0, frame_done 0, fill colour 0; in_ready reads 1 during and after reset.
REQ-029 Reset asserted mid-FILL or mid-SET_XY SHALL abort the operation with no further writes; partially received coordinates discarded.
REQ-030 Release of rst_n SHALL be followed by normal operation on the next rising clk edge.

Verification
REQ-031 Reset, send 0x15, 0x2A -> writes (0,0)=0x15 then (1,0)=0x2A on consecutive cycles, 1 cycle after each acceptance.
REQ-032 Send 0x40, 0x7F, 0x05, 0x3F -> single write (127,5)=0x3F; next pixel 0x01 writes (0,6)=0x01.
REQ-033 Send 0x40, 0x7F, 0x7F, 0x0C -> write (127,127)=0x0C with frame_done pulse; cursor now (0,0).
REQ-034 Send 0x80, 0x30 -> in_ready low, busy high for 16384 cycles, 16384 writes of 0x30 in raster order, frame_done on final write, then IDLE.
REQ-035 Hold in_valid with random stalls and illegal bytes (0x41, 0xFF) interleaved -> illegal bytes dropped, no writes, legal stream unaffected.
REQ-036 Assert rst_n low after 100 FILL cycles -> wr_en 0 immediately, busy 0, subsequent pixel 0x07 writes (0,0).
